// File: rtl/pll_reset_sequencer_pkg.sv
// rtl/pll_reset_sequencer_pkg.sv - state encoding, default parameters and sizing helpers
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int DEF_CHANNELS           = 4;
  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STEP_CYCLES        = 64;
  localparam int DEF_TIMEOUT_CYCLES     = 65536;
  localparam int DEF_MAX_RETRIES        = 3;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// rtl/pll_reset_sequencer_sync_2ff.sv - two-flop synchroniser with async active-low reset
module pll_reset_sequencer_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL supervisor: PLL reset, lock qualification, ordered channel release
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int CHANNELS           = DEF_CHANNELS,
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STEP_CYCLES        = DEF_STEP_CYCLES,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic                               clk27mhz,
  input  logic                               rst,
  input  logic                               pll_lock,
  input  logic                               force_relock,
  output logic                               pll_reset,
  output logic [CHANNELS-1:0]                chan_rst_n,
  output logic                               all_ready,
  output logic                               fault,
  output logic [cnt_w(MAX_RETRIES+1)-1:0]    retry_count
);

  localparam int CW = cnt_w(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, STEP_CYCLES));
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int RW = cnt_w(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
  localparam logic [CW-1:0] STAB_LAST = CW'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] retry_q;
  logic          lock_s;
  logic          stable_done;
  logic          restart;

  pll_reset_sequencer_sync_2ff u_lock_sync (
    .clk_i  (clk27mhz),
    .rst_ni (rst),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  assign stable_done = lock_s && ((state_q == ST_WAIT_LOCK) ? (LOCK_STABLE_CYCLES == 1)
                                                            : (cnt_q == STAB_LAST));
  assign restart = force_relock ||
                   (((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s);

  always_ff @(posedge clk27mhz or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_PLL_RST;
      cnt_q      <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      pll_reset  <= 1'b1;
      chan_rst_n <= '0;
      all_ready  <= 1'b0;
      fault      <= 1'b0;
    end else if (restart) begin
      state_q    <= ST_PLL_RST;
      cnt_q      <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      pll_reset  <= 1'b1;
      chan_rst_n <= '0;
      all_ready  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            tmo_q     <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          if (stable_done) begin
            state_q    <= ST_RELEASE;
            cnt_q      <= '0;
            chan_rst_n <= CHANNELS'(1);
          end else if (tmo_q == TMO_LAST) begin
            cnt_q     <= '0;
            tmo_q     <= '0;
            pll_reset <= 1'b1;
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + 1'b1;
              state_q <= ST_PLL_RST;
            end else begin
              state_q <= ST_FAULT;
              fault   <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (!lock_s) begin
              state_q <= ST_WAIT_LOCK;
            end else if (state_q == ST_WAIT_LOCK) begin
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            cnt_q <= '0;
            if (chan_rst_n[CHANNELS-1]) begin
              state_q   <= ST_RUN;
              all_ready <= 1'b1;
            end else begin
              chan_rst_n <= (chan_rst_n << 1) | CHANNELS'(1);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN, ST_FAULT: begin
          state_q <= state_q;
        end
        default: begin
          state_q    <= ST_PLL_RST;
          cnt_q      <= '0;
          tmo_q      <= '0;
          pll_reset  <= 1'b1;
          chan_rst_n <= '0;
          all_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign retry_count = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Parametrised PLL supervisor and reset sequencer running in the 27 MHz reference domain, placed between the board reset pin, the Gowin rPLL instance and the downstream logic. Holds the PLL in reset for a fixed time, waits for a qualified stable lock, then releases N downstream reset channels in order with fixed spacing. Lock loss, lock timeout with bounded retries, and a software-forced relock are handled without external help; retries exhausted raises a sticky fault.

## Interface
Parameters:
- CHANNELS, 4: number of sequenced downstream reset outputs (>=1)
- PLL_RST_CYCLES, 16: cycles pll_reset is held high per attempt (>=1)
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release (>=1)
- STEP_CYCLES, 64: spacing between successive channel releases (>=1)
- TIMEOUT_CYCLES, 65536: per-attempt limit from end of PLL reset to qualified lock (>= LOCK_STABLE_CYCLES+2)
- MAX_RETRIES, 3: extra PLL reset attempts after the first before fault (>=0)

Ports:
- clk27mhz  input  1  reference clock; single clock domain of the block
- rst  input  1  asynchronous, active-low reset
- pll_lock  input  1  PLL lock_o, asynchronous; synchronised internally
- force_relock  input  1  synchronous single-cycle request to restart the sequence
- pll_reset  output  1  active-high reset to the PLL
- chan_rst_n  output  CHANNELS  active-low per-channel resets, bit 0 released first
- all_ready  output  1  high only in RUN
- fault  output  1  sticky; high in FAULT
- retry_count  output  clog2(MAX_RETRIES+1), min 1  retries used in current sequence

## Operation
- Reset values (asynchronous on rst low): state PLL_RST, counters 0, pll_reset=1, chan_rst_n=all 0, all_ready=0, fault=0, retry_count=0, sync flops 0.
- pll_lock passes a 2-flop synchroniser → lock_s (2-cycle latency). All decisions use lock_s.
- PLL_RST: pll_reset=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with timeout counter cleared.
- WAIT_LOCK: pll_reset=0; lock_s=1 → STABLE, stable counter cleared. Timeout counter runs in WAIT_LOCK and STABLE.
- STABLE: lock_s=1 for LOCK_STABLE_CYCLES consecutive cycles → RELEASE; lock_s=0 → WAIT_LOCK (timeout counter not cleared).
- Timeout reached in WAIT_LOCK/STABLE: retry_count<MAX_RETRIES → retry_count+1, PLL_RST; else FAULT. Stable completion and timeout on the same cycle: stable completion wins.
- RELEASE: chan_rst_n[0] rises on the RELEASE entry edge; chan_rst_n[k] rises k*STEP_CYCLES cycles later; STEP_CYCLES after chan_rst_n[CHANNELS-1] rises → RUN.
- RUN: all_ready=1, chan_rst_n all 1.
- Lock loss (lock_s=0) in RELEASE or RUN: next edge chan_rst_n=all 0, all_ready=0, pll_reset=1, retry_count=0, → PLL_RST.
- FAULT: fault=1, pll_reset=1, chan_rst_n=all 0; exits only on rst or force_relock.
- force_relock=1 in any state: next edge → PLL_RST, counters and retry_count cleared, fault cleared, chan_rst_n=all 0, all_ready=0. Highest priority over every other event that cycle. In PLL_RST it restarts the PLL_RST count.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- pll_lock edge to lock_s: 2 cycles; lock_s rise to chan_rst_n[0] rise: LOCK_STABLE_CYCLES cycles.
- lock_s fall to all chan_rst_n low: 1 cycle.
- force_relock to outputs: 1 cycle.
- Counters sized for their largest terminal value; no wrap permitted in any state.
- rst assertion mid-sequence: outputs at reset values immediately, independent of clock.

## Structure
- Shared header pll_seq_defines.vh: state encodings (PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT), default parameter values, alongside pll_defines.vh.
- One sub-module: sync_2ff (2-flop synchroniser with async active-low reset) for pll_lock.
- Top-level design instantiates this block beside Gowin_rPLL: pll_reset → reset, lock_o → pll_lock.

## Test plan
Bench params: CHANNELS=4, PLL_RST_CYCLES=16, LOCK_STABLE_CYCLES=32, STEP_CYCLES=8, TIMEOUT_CYCLES=256, MAX_RETRIES=2.
- Clean bring-up: pll_lock rises 10 cycles after pll_reset falls, held → chan_rst_n=0001 at lock+34, 0011 at +42, 0111 at +50, 1111 at +58, all_ready at +66; pll_reset high exactly 16 cycles after rst release.
- Lock chatter: lock high 20 cycles, low 3, then held → no release until 34 cycles after final rise; retry_count stays 0.
- No lock ever → three pll_reset pulses of 16 cycles spaced 256 cycles, retry_count 0→1→2, then fault=1, pll_reset=1; force_relock → fault=0, retry_count=0, new 16-cycle pll_reset.
- Lock loss in RUN: drop pll_lock → chan_rst_n=0000, all_ready=0, pll_reset=1 within 3 cycles of the pin edge; relock repeats full sequence.
- force_relock and lock loss same cycle during RELEASE at 0011 → single PLL_RST entry, counters cleared, chan_rst_n=0000 next edge.
- rst low during RELEASE at 0011 → all outputs at reset values asynchronously; after release, sequence restarts from PLL_RST.
